// File: rtl/i2s_tx_ctrl.sv
`timescale 1ns/1ps
// I2S transmit sequencer: sclk divider, frame/slot sequencing and a stereo sample FIFO.
// Optional macro I2S_HOLD_LAST_EN: on underrun hold the last pair instead of outputting silence.
module i2s_tx_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    input  logic [WIDTH-1:0]         left_i,
    input  logic [WIDTH-1:0]         right_i,
    output logic                     sclk_o,
    output logic [WIDTH-1:0]         leftChan_o,
    output logic [WIDTH-1:0]         rightChan_o,
    output logic                     frame_o,
    output logic                     underrun_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(2 * WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [DW-1:0] DIV_MAX   = DW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(2 * WIDTH - 1);
    localparam logic [SW-1:0] SLOT_POP  = SW'(WIDTH - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic                 sclk_q, sclk_d;
    logic                 frame_q, frame_d;
    logic                 pop_q, pop_d;
    logic                 fall;

    logic [2*WIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]        level_q, level_d;
    logic [WIDTH-1:0]     left_q, left_d, right_q, right_d;
    logic                 underrun_q, underrun_d;
    logic                 push, pop_hit, pop_miss;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        slot_d  = slot_q;
        sclk_d  = sclk_q;
        fall    = 1'b0;
        if (state_q != IDLE) begin
            if (div_q == DIV_MAX) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                if (sclk_q) begin
                    fall   = 1'b1;
                    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        frame_d = fall && (slot_d == '0);
        pop_d   = fall && (slot_d == SLOT_POP);
        case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            default: begin
                // Stopping only on the fall into the last slot keeps slot alignment for the next start.
                if (en_i)                             state_d = RUN;
                else if (fall && slot_d == SLOT_LAST) state_d = IDLE;
                else                                  state_d = STOP;
            end
        endcase
    end

    assign sample_ready_o = (level_q < LVL_FULL);
    assign push           = sample_valid_i && sample_ready_o;
    assign pop_hit        = pop_q && (level_q != '0);
    assign pop_miss       = pop_q && (level_q == '0);

    always_comb begin
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop_hit ? rd_q + 1'b1 : rd_q;
        level_d    = level_q;
        left_d     = left_q;
        right_d    = right_q;
        underrun_d = pop_miss;
        if (push && !pop_hit)      level_d = level_q + 1'b1;
        else if (pop_hit && !push) level_d = level_q - 1'b1;
        if (pop_hit) begin
            {left_d, right_d} = mem_q[rd_q];
        end else if (pop_miss) begin
`ifdef I2S_HOLD_LAST_EN
            left_d  = left_q;
            right_d = right_q;
`else
            left_d  = '0;
            right_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= {left_i, right_i};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            div_q      <= '0;
            slot_q     <= SLOT_LAST;
            sclk_q     <= 1'b0;
            frame_q    <= 1'b0;
            pop_q      <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            left_q     <= '0;
            right_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            slot_q     <= slot_d;
            sclk_q     <= sclk_d;
            frame_q    <= frame_d;
            pop_q      <= pop_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            left_q     <= left_d;
            right_q    <= right_d;
            underrun_q <= underrun_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign frame_o     = frame_q;
    assign underrun_o  = underrun_q;
    assign leftChan_o  = left_q;
    assign rightChan_o = right_q;
    assign level_o     = level_q;

endmodule

// File: doc/i2s_tx_ctrl.md
# i2s_tx_ctrl

Sequencer that drives the I2S transmit serializer from the system clock domain. Divides `clk_i` down to the serial bit clock `sclk_o`. Buffers stereo samples from the DSP path in a small FIFO with a valid/ready handshake. Presents a stable left/right pair to the serializer once per frame, away from its load edge, and handles underrun. Sits between the audio processing pipeline and the serializer, which runs on `sclk_o`.

## Interface
Parameters:
- `WIDTH`, 16: bits per channel; frame = 2*WIDTH sclk periods.
- `DIV`, 4: `clk_i` cycles per sclk half-period (≥2); sclk period = 2*DIV clk.
- `DEPTH`, 4: FIFO depth in stereo pairs, power of two ≥2.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-low reset; clears all state.
- `en_i` in 1: run enable.
- `sample_valid_i` in 1: DSP sample pair valid.
- `sample_ready_o` out 1: FIFO can accept a pair.
- `left_i` in WIDTH: left sample.
- `right_i` in WIDTH: right sample.
- `sclk_o` out 1: bit clock to serializer.
- `leftChan_o` out WIDTH: left sample to serializer.
- `rightChan_o` out WIDTH: right sample to serializer.
- `frame_o` out 1: one-clk pulse at frame start.
- `underrun_o` out 1: one-clk pulse when a pop finds the FIFO empty.
- `level_o` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Reset values: `sclk_o`=0, `leftChan_o`=`rightChan_o`=0, `frame_o`=0, `underrun_o`=0, `level_o`=0, `sample_ready_o`=1. Divider count=0. Slot counter=2*WIDTH-1. State=IDLE.
- States:
  - IDLE: `sclk_o` held 0, divider and slot counter held. `en_i`=1 → RUN.
  - RUN: divider counts 0..DIV-1. At DIV-1 it wraps and toggles `sclk_o`.
  - STOP: entered when `en_i`=0 in RUN. Keeps clocking until the falling edge that sets slot=2*WIDTH-1, then → IDLE with `sclk_o`=0. `en_i`=1 in STOP → RUN without gap.
- Falling edge event: the toggle taking `sclk_o` 1→0. On each event, slot increments modulo 2*WIDTH (2*WIDTH-1 → 0).
- Slot→0 event: `frame_o` pulses in the same clk as the toggle.
- Slot→WIDTH-1 event: pop.
  - FIFO non-empty: head pair loaded into `leftChan_o`/`rightChan_o` on the next clk.
  - FIFO empty: `underrun_o` pulses, and the outputs follow the Configuration rule.
- Pop timing: the serializer latches at its slot 2*WIDTH-2. Popping at slot WIDTH-1 gives ≥WIDTH-1 sclk periods of setup and hold.
- FIFO:
  - Push when `sample_valid_i`&&`sample_ready_o`.
  - `sample_ready_o` = (level<DEPTH), combinational from registered level.
  - Push and pop in the same clk: level unchanged, ordering preserved.
  - Pop on an empty FIFO with a same-clk push: counts as underrun. There is no bypass; the pushed pair is stored.
  - Pointers wrap modulo DEPTH. `level_o` saturates at DEPTH.
- Reset mid-frame: all state cleared immediately. FIFO contents discarded. Restart begins at slot 2*WIDTH-1, which keeps the slot counter aligned with a serializer reset by the same reset.

## Timing
- sclk duty 50%: high DIV clk, low DIV clk.
- First `sclk_o` rise DIV clk after entering RUN. First falling edge at 2*DIV clk, and slot becomes 0 there.
- Pop-to-output latency: 1 clk after the slot WIDTH-1 falling-edge event.
- Push-to-`level_o` latency: 1 clk. `sample_ready_o` deasserts the clk after the push that fills the FIFO.
- Frame period 2*WIDTH*2*DIV clk; 256 clk for default parameters.

## Configuration
- `I2S_HOLD_LAST_EN` defined: on underrun, `leftChan_o`/`rightChan_o` keep their previous values.
- Not defined: on underrun, both are cleared to 0 (silence).
- `underrun_o` pulses identically in both builds.

## Test plan
- Reset, `en_i`=1, defaults:
  - `sclk_o` period 8 clk.
  - `frame_o` pulses every 256 clk.
  - The first `frame_o` coincides with the first `sclk_o` fall, at clk 8.
- Push pairs (0x1234,0xABCD) and (0x0F0F,0xF0F0) before enable. Outputs take 0x1234/0xABCD 1 clk after the slot-15 fall, and 0x0F0F/0xF0F0 one frame later.
- Push 5 pairs with `sample_valid_i` held high at DEPTH=4:
  - `sample_ready_o` drops after the 4th push and `level_o`=4.
  - The 5th pair is held until the next pop, then accepted.
- Empty FIFO at a pop:
  - `underrun_o` pulses once per frame.
  - Outputs hold the last pair with `I2S_HOLD_LAST_EN` defined, and become 0x0000/0x0000 without it.
- Drop `en_i` at slot 5:
  - `sclk_o` continues until the falling edge setting slot 31, then stays 0.
  - Re-enabling makes the first fall set slot 0.
- Assert `rst_i`=0 mid-frame with level=3:
  - All outputs go to reset values asynchronously and `level_o`=0.
  - After release, the frame restarts at slot 31.
